light_level_arbiter: RTL and testbench

- Owns the room light level. Arbitrates between two requesters: IR remote level commands and the occupancy counter, which supplies the people count (0..99).
- Holds a target level 0..5 and ramps the displayed level one step at a time toward it on a fixed prescaled cadence.
- Drives the 4-bit LED bar with the house thermometer mapping.
- Sits between the IR/occupancy front ends and the LED pins, replacing ad-hoc level writes.

---
 rtl/light_level_arbiter_if.sv | 16 +
 rtl/light_level_arbiter.sv | 121 ++++++++++++
 tb/tb_light_level_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/light_level_arbiter_if.sv
// light_level_arbiter_if: request inputs and light-level outputs of the arbiter
interface light_level_arbiter_if;
   logic       clear;
   logic       ir_valid;
   logic [2:0] ir_level;
   logic [6:0] occ_count;
   logic [2:0] level;
   logic [2:0] target;
   logic [3:0] led;
   logic       busy;
   logic [1:0] src;
   modport master (output clear, ir_valid, ir_level, occ_count,
                   input  level, target, led, busy, src);
   modport slave  (input  clear, ir_valid, ir_level, occ_count,
                   output level, target, led, busy, src);
endinterface

// File: rtl/light_level_arbiter.sv
// light_level_arbiter: arbitrates IR/occupancy requests and ramps the room light level; LLA_VACANCY_DELAY_EN delays switch-off on vacancy
module light_level_arbiter #(
   parameter int RAMP_DIV      = 4,
   parameter int DEFAULT_LEVEL = 3,
   parameter int VACANCY_TICKS = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   light_level_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_t;
   localparam int DW = $clog2(RAMP_DIV);

   if (RAMP_DIV < 2 || DEFAULT_LEVEL < 1 || DEFAULT_LEVEL > 5 || VACANCY_TICKS < 1) begin : g_bad_param
      $error("light_level_arbiter: parameter out of range");
   end

   ramp_t          st, st_n;
   logic [DW-1:0]  div, div_n;
   logic [2:0]     level, level_n, target, target_n;
   logic [1:0]     src, src_n;
   logic           hold, hold_n, occ_nz_q;
   logic           occ_nz, rise, fall, ir_ok, occ_on, occ_off, step;

   assign occ_nz = |bus.occ_count;
   assign rise   = occ_nz & ~occ_nz_q;
   assign fall   = ~occ_nz & occ_nz_q;
   assign ir_ok  = bus.ir_valid && bus.ir_level <= 3'd5;
   assign step   = st != IDLE && div == DW'(RAMP_DIV - 1);

`ifdef LLA_VACANCY_DELAY_EN
   typedef enum logic {OCCUPIED, VACANT_WAIT} vac_t;
   localparam int VW = $clog2(VACANCY_TICKS + 1);
   vac_t          vst, vst_n;
   logic [VW-1:0] vcnt, vcnt_n;
   logic          expire;

   assign expire  = vst == VACANT_WAIT && vcnt == VW'(1);
   assign occ_on  = rise && vst == OCCUPIED;
   assign occ_off = expire && !rise;

   // vacancy wait: a fall arms the countdown, any winning request or a return cancels it
   always_comb begin
      vst_n  = vst;
      vcnt_n = vcnt;
      if (bus.clear || ir_ok || rise || expire) vst_n = OCCUPIED;
      else if (fall) begin
         vst_n  = VACANT_WAIT;
         vcnt_n = VW'(VACANCY_TICKS);
      end else if (vst == VACANT_WAIT) vcnt_n = vcnt - VW'(1);
   end

   // vacancy wait registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vst  <= OCCUPIED;
         vcnt <= '0;
      end else begin
         vst  <= vst_n;
         vcnt <= vcnt_n;
      end
   end
`else
   assign occ_on  = rise;
   assign occ_off = fall;
`endif

   // arbitration (clear > valid IR > occupancy) and one-step ramp toward target
   always_comb begin
      target_n = target;
      hold_n   = hold;
      src_n    = src;
      level_n  = step ? (st == UP ? level + 3'd1 : level - 3'd1) : level;
      if (bus.clear) begin
         target_n = 3'd0;
         hold_n   = 1'b0;
         src_n    = 2'd0;
         level_n  = 3'd0;
      end else if (ir_ok) begin
         target_n = bus.ir_level;
         hold_n   = bus.ir_level != 3'd0;
         src_n    = 2'd2;
      end else if (occ_on && !hold) begin
         target_n = 3'(DEFAULT_LEVEL);
         src_n    = 2'd1;
      end else if (occ_off) begin
         target_n = 3'd0;
         hold_n   = 1'b0;
         src_n    = 2'd1;
      end
      st_n  = level_n == target_n ? IDLE : (level_n < target_n ? UP : DOWN);
      div_n = (st == IDLE || st_n == IDLE || step) ? '0 : div + DW'(1);
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         div      <= '0;
         level    <= 3'd0;
         target   <= 3'd0;
         src      <= 2'd0;
         hold     <= 1'b0;
         occ_nz_q <= 1'b0;
      end else begin
         st       <= st_n;
         div      <= div_n;
         level    <= level_n;
         target   <= target_n;
         src      <= src_n;
         hold     <= hold_n;
         occ_nz_q <= occ_nz;
      end
   end

   assign bus.level  = level;
   assign bus.target = target;
   assign bus.src    = src;
   assign bus.busy   = level != target;
   assign bus.led    = level < 3'd2 ? 4'd0 : 4'((5'd1 << (level - 3'd1)) - 5'd1);
endmodule

// File: tb/tb_light_level_arbiter.sv
// tb_light_level_arbiter: directed and random stimulus against a cycle-stamp reference model
module tb_light_level_arbiter;
   localparam int RAMP_DIV      = 4;
   localparam int DEFAULT_LEVEL = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   light_level_arbiter_if bus ();
   light_level_arbiter #(.RAMP_DIV(RAMP_DIV), .DEFAULT_LEVEL(DEFAULT_LEVEL), .VACANCY_TICKS(8))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int checks = 0;
   int errors = 0;
   int m_level = 0, m_target = 0, m_src = 0, m_next = 0, cyc = 0;
   bit m_hold = 0, m_occ_q = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int led_of(input int l);
      case (l)
         2: return 1;
         3: return 3;
         4: return 7;
         5: return 15;
         default: return 0;
      endcase
   endfunction

   // reference: a ramp step is due at an absolute edge number, RAMP_DIV edges after the ramp starts or the last step
   task automatic model_edge();
      bit was_busy, stepped, nz, rise, fall;
      cyc++;
      was_busy = m_level != m_target;
      stepped = 0;
      if (was_busy && cyc == m_next) begin
         m_level += (m_target > m_level) ? 1 : -1;
         stepped = 1;
      end
      nz = bus.occ_count != 0;
      rise = nz && !m_occ_q;
      fall = !nz && m_occ_q;
      m_occ_q = nz;
      if (bus.clear) begin
         m_level = 0; m_target = 0; m_hold = 0; m_src = 0;
      end else if (bus.ir_valid && bus.ir_level <= 5) begin
         m_target = bus.ir_level; m_src = 2; m_hold = bus.ir_level != 0;
      end else if (rise) begin
         if (!m_hold) begin m_target = DEFAULT_LEVEL; m_src = 1; end
      end else if (fall) begin
         m_target = 0; m_hold = 0; m_src = 1;
      end
      if (m_level != m_target && (!was_busy || stepped)) m_next = cyc + RAMP_DIV;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("level", bus.level, m_level);
      check("target", bus.target, m_target);
      check("led", bus.led, led_of(m_level));
      check("busy", bus.busy, m_level != m_target);
      check("src", bus.src, m_src);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input bit clr, input bit v, input int lv);
      bus.clear = clr;
      bus.ir_valid = v;
      bus.ir_level = 3'(lv);
      tick();
      bus.clear = 1'b0;
      bus.ir_valid = 1'b0;
   endtask

   initial begin
      bus.clear = 1'b0;
      bus.ir_valid = 1'b0;
      bus.ir_level = 3'd0;
      bus.occ_count = 7'd0;
      #12;
      check("rst_level", bus.level, 0);
      check("rst_target", bus.target, 0);
      check("rst_led", bus.led, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_src", bus.src, 0);
      @(negedge clk) rst_n = 1'b1;
      run(9);
      bus.occ_count = 7'd1;
      run(1);
      check("rise_target", bus.target, 3);
      run(20);
      check("rise_level", bus.level, 3);
      check("rise_led", bus.led, 4'b0011);
      pulse(0, 1, 5);
      run(10);
      check("ir5_level", bus.level, 5);
      check("ir5_led", bus.led, 4'b1111);
      bus.occ_count = 7'd2; run(2);
      bus.occ_count = 7'd3; run(2);
      check("hold_target", bus.target, 5);
      bus.occ_count = 7'd0;
      run(25);
      check("fall_level", bus.level, 0);
      bus.occ_count = 7'd1;
      pulse(0, 1, 2);
      run(10);
      check("tie_target", bus.target, 2);
      check("tie_src", bus.src, 2);
      pulse(1, 0, 0);
      pulse(0, 1, 5);
      run(8);
      check("mid_level", bus.level, 2);
      pulse(1, 0, 0);
      check("clr_level", bus.level, 0);
      check("clr_src", bus.src, 0);
      pulse(0, 1, 7);
      check("bad_ir_target", bus.target, 0);
      pulse(0, 1, 5);
      run(11);
      pulse(0, 1, 1);
      run(10);
      check("rev_level", bus.level, 1);
      check("rev_busy", bus.busy, 0);
      repeat (3000) begin
         if ($urandom_range(0, 39) == 0)
            bus.occ_count = $urandom_range(0, 1) ? 7'($urandom_range(1, 99)) : 7'd0;
         bus.ir_valid = $urandom_range(0, 11) == 0;
         bus.ir_level = 3'($urandom_range(0, 7));
         bus.clear = $urandom_range(0, 149) == 0;
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
